// File: rtl/pipe_barrel_shifter_pkg.sv
// Shared op encodings and legality check for the pipelined barrel shifter.
// PIPE_BARREL_SHIFTER_ROTATE_EN makes ROL/ROR legal ops; otherwise they are reserved.
package shifter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b010;
    localparam logic [OP_W-1:0] OP_ROL = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR = 3'b100;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
        return (op <= OP_ROR);
`else
        return (op <= OP_SRA);
`endif
    endfunction

endpackage

// File: rtl/pipe_barrel_shifter_if.sv
// Operand/result handshake bundle of the shifter: valid/ready on both ends plus flush.
// The slave modport is the shifter side; the master modport is the producer/consumer side.
interface pipe_barrel_shifter_if
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] din;
    logic [SHAMT_W-1:0]    shamt;
    logic [OP_W-1:0]       op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] dout;

    modport slave (
        input  flush, in_valid, din, shamt, op, out_ready,
        output in_ready, out_valid, dout
    );

    modport master (
        output flush, in_valid, din, shamt, op, out_ready,
        input  in_ready, out_valid, dout
    );
endinterface

// File: rtl/pipe_barrel_shifter_stage.sv
// One pipeline level: conditionally shifts by 2^STAGE, registers valid/data/shamt/op/sign; 1 cycle.
// Loads when empty or when downstream takes its contents; holds otherwise. ROL/ROR muxes under PIPE_BARREL_SHIFTER_ROTATE_EN.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE      = 0,
    localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  up_vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    input  logic [OP_W-1:0]       op_i,
    input  logic                  sign_i,
    input  logic                  dn_rdy_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SHAMT_W-1:0]    shamt_o,
    output logic [OP_W-1:0]       op_o,
    output logic                  sign_o
);
    localparam int SH = 1 << STAGE;

    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SHAMT_W-1:0]    shamt_q;
    logic [OP_W-1:0]       op_q;
    logic                  sign_q;
    logic                  load;

    // Reserved ops collapse to zero at every level so the result stays zero.
    always_comb begin
        dat_d = dat_i;
        if (!is_legal_op(op_i)) begin
            dat_d = '0;
        end else if (shamt_i[STAGE]) begin
            unique case (op_i)
                OP_SLL:  dat_d = dat_i << SH;
                OP_SRL:  dat_d = dat_i >> SH;
                OP_SRA:  dat_d = (dat_i >> SH) | ({DATA_WIDTH{sign_i}} << (DATA_WIDTH - SH));
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
                OP_ROL:  dat_d = (dat_i << SH) | (dat_i >> (DATA_WIDTH - SH));
                OP_ROR:  dat_d = (dat_i >> SH) | (dat_i << (DATA_WIDTH - SH));
`endif
                default: dat_d = '0;
            endcase
        end
    end

    assign load = !vld_q || dn_rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            dat_q   <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (load) begin
            vld_q <= up_vld_i;
            if (up_vld_i) begin
                dat_q   <= dat_d;
                shamt_q <= shamt_i;
                op_q    <= op_i;
                sign_q  <= sign_i;
            end
        end
    end

    assign vld_o   = vld_q;
    assign dat_o   = dat_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter, one log2 level per stage; latency SHAMT_W cycles, 1 op/cycle.
// Ready chain is combinational back to front; stalls hold the output; flush empties the pipe. Rotate via PIPE_BARREL_SHIFTER_ROTATE_EN.
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_barrel_shifter_if.slave  bus
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    // Index 0 is the input port; index k+1 is the register set of stage k.
    logic                  vld   [0:SHAMT_W];
    logic [DATA_WIDTH-1:0] dat   [0:SHAMT_W];
    logic [SHAMT_W-1:0]    shamt [0:SHAMT_W];
    logic [OP_W-1:0]       opr   [0:SHAMT_W];
    logic                  sgn   [0:SHAMT_W];
    logic [SHAMT_W:0]      rdy;
    logic                  unused_tail;

    assign vld[0]   = bus.in_valid && !bus.flush;
    assign dat[0]   = bus.din;
    assign shamt[0] = bus.shamt;
    assign opr[0]   = bus.op;
    assign sgn[0]   = bus.din[DATA_WIDTH-1];

    always_comb begin
        rdy = '0;
        rdy[SHAMT_W] = bus.out_ready;
        for (int k = SHAMT_W - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGE      (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (bus.flush),
            .up_vld_i (vld[k]),
            .dat_i    (dat[k]),
            .shamt_i  (shamt[k]),
            .op_i     (opr[k]),
            .sign_i   (sgn[k]),
            .dn_rdy_i (rdy[k+1]),
            .vld_o    (vld[k+1]),
            .dat_o    (dat[k+1]),
            .shamt_o  (shamt[k+1]),
            .op_o     (opr[k+1]),
            .sign_o   (sgn[k+1])
        );
    end

    assign bus.in_ready  = rdy[0] && !bus.flush;
    assign bus.out_valid = vld[SHAMT_W];
    assign bus.dout      = dat[SHAMT_W];

    assign unused_tail = ^{shamt[SHAMT_W], opr[SHAMT_W], sgn[SHAMT_W]};

endmodule
